adsr_multivoice: RTL

//   Time-multiplexed ADSR envelope generator and VCA for NUM_VOICES voices.

---
 rtl/adsr_multivoice.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/adsr_multivoice.sv
// Time-multiplexed ADSR envelope generator and VCA: one voice update per accepted sample,
// with per-voice state, envelope and latched rates held internally.
module adsr_multivoice #(
  parameter int NUM_VOICES = 8,
  parameter int SAMPLE_W   = 16,
  parameter int ENV_W      = 24,
  parameter int RATE_W     = 16,
  parameter int VOICE_W    = $clog2(NUM_VOICES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [RATE_W-1:0]          attack_amt,
  input  logic [RATE_W-1:0]          decay_amt,
  input  logic [RATE_W-1:0]          sustain_amt,
  input  logic [RATE_W-1:0]          rel_amt,
  input  logic [NUM_VOICES-1:0]      key_state,
  input  logic                       in_valid,
  input  logic [VOICE_W-1:0]         in_voice,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       out_valid,
  output logic [VOICE_W-1:0]         out_voice,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic [NUM_VOICES-1:0]      voice_active
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [ENV_W-1:0]   FULL   = '1;
  localparam logic [VOICE_W:0]   NV_EXT = (VOICE_W+1)'(NUM_VOICES);

  state_t              state_q [NUM_VOICES];
  logic [ENV_W-1:0]    env_q   [NUM_VOICES];
  logic [RATE_W-1:0]   atk_q   [NUM_VOICES];
  logic [RATE_W-1:0]   dec_q   [NUM_VOICES];
  logic [RATE_W-1:0]   sus_q   [NUM_VOICES];
  logic [RATE_W-1:0]   rel_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q;

  logic                       vld_p0_q;
  logic [VOICE_W-1:0]         voice_p0_q;
  logic signed [SAMPLE_W-1:0] sample_p0_q;
  logic [SAMPLE_W-1:0]        gain_p0_q;
  logic                       out_valid_q;
  logic [VOICE_W-1:0]         out_voice_q;
  logic signed [SAMPLE_W-1:0] out_sample_q;

  function automatic logic [ENV_W-1:0] env_rise(input logic [ENV_W-1:0] env,
                                                input logic [RATE_W-1:0] rate);
    logic [ENV_W:0] sum;
    sum = {1'b0, env} + (ENV_W+1)'(rate);
    return (sum >= {1'b0, FULL}) ? FULL : sum[ENV_W-1:0];
  endfunction

  // Steps down by rate but never below floor_lvl; lands exactly on floor_lvl when close.
  function automatic logic [ENV_W-1:0] env_fall(input logic [ENV_W-1:0] env,
                                                input logic [ENV_W-1:0] floor_lvl,
                                                input logic [RATE_W-1:0] rate);
    logic [ENV_W:0] lim;
    lim = {1'b0, floor_lvl} + (ENV_W+1)'(rate);
    return ({1'b0, env} <= lim) ? floor_lvl : env - ENV_W'(rate);
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] scale_floor(input logic signed [SAMPLE_W-1:0] s,
                                                             input logic [SAMPLE_W-1:0] g);
    logic signed [2*SAMPLE_W:0] prod;
    prod = s * $signed({1'b0, g});
    return prod[2*SAMPLE_W-1:SAMPLE_W];
  endfunction

  logic [VOICE_W:0]  voice_ext;
  logic              hit;
  logic              key;
  state_t            cur_state;
  logic [ENV_W-1:0]  cur_env;
  logic [RATE_W-1:0] cur_atk, cur_dec, cur_sus, cur_rel;
  logic [ENV_W-1:0]  target;
  state_t            state_d;
  logic [ENV_W-1:0]  env_d;
  logic              latch;

  assign voice_ext = {1'b0, in_voice};
  assign hit       = in_valid && (voice_ext < NV_EXT);
  assign key       = key_state[in_voice];
  assign cur_state = state_q[in_voice];
  assign cur_env   = env_q[in_voice];
  assign cur_atk   = atk_q[in_voice];
  assign cur_dec   = dec_q[in_voice];
  assign cur_sus   = sus_q[in_voice];
  assign cur_rel   = rel_q[in_voice];
  assign target    = ENV_W'(cur_sus) << (ENV_W - RATE_W);

  always_comb begin
    state_d = cur_state;
    env_d   = cur_env;
    latch   = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (key) begin
          latch   = 1'b1;
          state_d = ST_ATTACK;
        end
      end
      ST_ATTACK: begin
        if (!key) begin
          state_d = ST_RELEASE;
        end else begin
          env_d   = (cur_atk == '0) ? FULL : env_rise(cur_env, cur_atk);
          state_d = (env_d == FULL) ? ST_DECAY : ST_ATTACK;
        end
      end
      ST_DECAY: begin
        if (!key) begin
          state_d = ST_RELEASE;
        end else begin
          env_d   = (cur_dec == '0) ? target : env_fall(cur_env, target, cur_dec);
          state_d = (env_d == target) ? ST_SUSTAIN : ST_DECAY;
        end
      end
      ST_SUSTAIN: begin
        if (!key) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Retrigger keeps the current level so the attack restarts without a click.
        if (key) begin
          latch   = 1'b1;
          state_d = ST_ATTACK;
        end else begin
          env_d   = (cur_rel == '0) ? '0 : env_fall(cur_env, '0, cur_rel);
          state_d = (env_d == '0) ? ST_IDLE : ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        env_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= ST_IDLE;
        env_q[i]   <= '0;
        atk_q[i]   <= '0;
        dec_q[i]   <= '0;
        sus_q[i]   <= '0;
        rel_q[i]   <= '0;
      end
      active_q <= '0;
    end else if (hit) begin
      state_q[in_voice]  <= state_d;
      env_q[in_voice]    <= env_d;
      active_q[in_voice] <= (state_d != ST_IDLE);
      if (latch) begin
        atk_q[in_voice] <= attack_amt;
        dec_q[in_voice] <= decay_amt;
        sus_q[in_voice] <= sustain_amt;
        rel_q[in_voice] <= rel_amt;
      end
    end
  end

  // Stage p0: sample registered with the pre-update gain of its voice.
  always_ff @(posedge clk) begin
    if (hit) begin
      sample_p0_q <= in_sample;
      gain_p0_q   <= cur_env[ENV_W-1 -: SAMPLE_W];
    end
  end

  // Stage p1: scaled output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0_q     <= 1'b0;
      voice_p0_q   <= '0;
      out_valid_q  <= 1'b0;
      out_voice_q  <= '0;
      out_sample_q <= '0;
    end else begin
      vld_p0_q    <= hit;
      if (hit) voice_p0_q <= in_voice;
      out_valid_q <= vld_p0_q;
      if (vld_p0_q) begin
        out_voice_q  <= voice_p0_q;
        out_sample_q <= scale_floor(sample_p0_q, gain_p0_q);
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_voice    = out_voice_q;
  assign out_sample   = out_sample_q;
  assign voice_active = active_q;

endmodule
